// File: rtl/mat_add_host.sv
// mat_add_host: loads two 4x4 byte matrices, pulses an external adder, captures and streams the 16-bit result.
// Optional result checker enabled by defining MAT_ADD_HOST_CHECK_EN.
module mat_add_host #(
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  output logic [3:0][3:0][7:0]   acc_a,
  output logic [3:0][3:0][7:0]   acc_b,
  output logic                   acc_start,
  input  logic                   acc_done,
  input  logic [3:0][3:0][15:0]  acc_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   err_timeout,
  output logic                   err_mismatch
);
  typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;
  state_t               r_state, w_next;
  logic [4:0]           r_lcnt;
  logic [15:0]          r_cnt;
  logic [3:0]           r_idx;
  logic [3:0][3:0][15:0] r_buf;
  logic                 r_err_timeout;
  logic                 w_in_hs, w_out_hs, w_start_end, w_tmo, w_cap;

  assign w_in_hs     = in_valid && in_ready;
  assign w_out_hs    = out_valid && out_ready;
  assign w_start_end = r_cnt == 16'(START_CYCLES - 1);
  assign w_tmo       = !acc_done && r_cnt == 16'(TIMEOUT_CYCLES - 1);
  assign w_cap       = r_state == WAIT && acc_done;

  always_ff @(posedge clk)
    r_state <= rst ? LOAD : w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:  if (w_in_hs && r_lcnt == 5'd31) w_next = START;
      START: if (w_start_end) w_next = WAIT;
      WAIT:  w_next = acc_done ? DRAIN : w_tmo ? LOAD : WAIT;
      DRAIN: if (w_out_hs && r_idx == 4'd15) w_next = LOAD;
    endcase
  end

  // Outputs are forced to their idle values while rst is held, whatever state is still registered.
  always_comb begin
    in_ready    = !rst && r_state == LOAD;
    acc_start   = !rst && r_state == START;
    out_valid   = !rst && r_state == DRAIN;
    out_last    = out_valid && r_idx == 4'd15;
    busy        = !rst && r_state != LOAD;
    out_data    = r_buf[r_idx[3:2]][r_idx[1:0]];
    err_timeout = !rst && r_err_timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lcnt        <= '0;
      r_cnt         <= '0;
      r_idx         <= '0;
      acc_a         <= '0;
      acc_b         <= '0;
      r_buf         <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_in_hs) begin
        if (r_lcnt[4]) acc_b[r_lcnt[3:2]][r_lcnt[1:0]] <= in_data;
        else acc_a[r_lcnt[3:2]][r_lcnt[1:0]] <= in_data;
        r_lcnt <= r_lcnt + 5'd1;
      end
      r_cnt <= (r_state == START && !w_start_end) || (r_state == WAIT && !acc_done && !w_tmo) ? r_cnt + 16'd1 : '0;
      if (w_cap) begin
        r_buf <= acc_c;
        r_idx <= '0;
      end else if (w_out_hs) r_idx <= r_idx + 4'd1;
      if (r_state == WAIT && w_tmo) r_err_timeout <= 1'b1;
    end
  end

`ifdef MAT_ADD_HOST_CHECK_EN
  logic r_err_mismatch, w_mis;

  always_comb begin
    w_mis = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (acc_c[i][j] != 16'(acc_a[i][j]) + 16'(acc_b[i][j])) w_mis = 1'b1;
  end

  always_ff @(posedge clk)
    if (rst) r_err_mismatch <= 1'b0;
    else if (w_cap && w_mis) r_err_mismatch <= 1'b1;

  assign err_mismatch = !rst && r_err_mismatch;
`else
  assign err_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_mat_add_host.sv
// tb_mat_add_host: table-driven batches through a behavioural adder, plus timeout and reset sequences.
module tb_mat_add_host;
  typedef struct {
    logic [7:0]  a0, a_step, b0, b_step;
    logic [15:0] e0, e_step;
    bit          toggle, early, corrupt;
  } vec_t;

  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic [3:0][3:0][7:0] acc_a, acc_b;
  logic [3:0][3:0][15:0] acc_c;
  logic acc_start, acc_done = 0, m_good = 0, start_q = 0;
  logic out_valid, out_last, busy, err_timeout, err_mismatch, in_ready;
  logic [15:0] out_data;
  bit model_en = 1, early = 0, corrupt = 0;
  int mcnt = 0, run = 0, last_run = 0, pulses = 0;
  int checks = 0, errors = 0;
  vec_t tbl[4];
  vec_t rv;

  mat_add_host #(.START_CYCLES(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .acc_a(acc_a), .acc_b(acc_b), .acc_start(acc_start), .acc_done(acc_done), .acc_c(acc_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err_timeout(err_timeout), .err_mismatch(err_mismatch)
  );

  always #5 clk = ~clk;

  // Adder model: done 3 cycles after start rises; result is valid only on that real done, garbage otherwise.
  always @(posedge clk) begin
    start_q  <= acc_start;
    acc_done <= 1'b0;
    m_good   <= 1'b0;
    if (!model_en) mcnt <= 0;
    else if (acc_start && !start_q) begin
      mcnt <= 1;
      if (early) acc_done <= 1'b1;
    end else if (mcnt == 3) begin
      mcnt     <= 0;
      acc_done <= 1'b1;
      m_good   <= 1'b1;
    end else if (mcnt > 0) mcnt <= mcnt + 1;
  end

  always_comb begin
    acc_c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        acc_c[i][j] = m_good ? 16'(acc_a[i][j]) + 16'(acc_b[i][j]) + ((corrupt && i == 2 && j == 1) ? 16'd1 : 16'd0) : 16'hDEAD;
  end

  always @(negedge clk) begin
    if (acc_start) run <= run + 1;
    else if (run > 0) begin
      last_run <= run;
      pulses   <= pulses + 1;
      run      <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input vec_t v, input int k);
    return k < 16 ? v.a0 + v.a_step * 8'(k) : v.b0 + v.b_step * 8'(k - 16);
  endfunction

  task automatic load(input vec_t v, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) chk("in_ready_load", in_ready, 1);
      in_valid = 1;
      in_data  = byte_of(v, k);
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic run_batch(input vec_t v, input bit exp_to);
    int k, cyc, p0;
    logic [15:0] e;
    bit mis;
`ifdef MAT_ADD_HOST_CHECK_EN
    mis = v.corrupt;
`else
    mis = 0;
`endif
    early   = v.early;
    corrupt = v.corrupt;
    p0      = pulses;
    load(v, 32);
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 0);
    chk("start_pulse", acc_start, 1);
    k = 0;
    cyc = 0;
    while (k < 16 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        e = v.e0 + v.e_step * 16'(k) + ((v.corrupt && k == 9) ? 16'd1 : 16'd0);
        chk("out_data", out_data, e);
        chk("out_last", out_last, k == 15);
      end
      out_ready = v.toggle ? cyc[0] : 1'b1;
      if (out_valid && out_ready) k++;
    end
    if (k < 16) chk("drain_count", k, 16);
    @(negedge clk);
    out_ready = 0;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_err_timeout", err_timeout, exp_to);
    chk("post_err_mismatch", err_mismatch, mis);
    chk("start_width", last_run, 2);
    chk("start_pulses", pulses - p0, 1);
    chk("acc_a_hold", acc_a[3][3], byte_of(v, 15));
    chk("acc_b_hold", acc_b[3][3], byte_of(v, 31));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    tbl[0] = '{8'hFF, 8'h00, 8'h01, 8'h00, 16'h0100, 16'h0000, 0, 0, 0};
    tbl[1] = '{8'h00, 8'h01, 8'h00, 8'h02, 16'h0000, 16'h0003, 1, 0, 0};
    tbl[2] = '{8'h00, 8'h11, 8'hFF, 8'h00, 16'h00FF, 16'h0011, 0, 1, 0};
    tbl[3] = '{8'h80, 8'h01, 8'h80, 8'h00, 16'h0100, 16'h0001, 1, 1, 0};
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc_start", acc_start, 0);
    chk("rst_acc_a", acc_a == '0, 1);
    rst = 0;
    #1 chk("rst_release_in_ready", in_ready, 1);
    for (int t = 0; t < 4; t++) run_batch(tbl[t], 0);
    // Timeout: adder never answers.
    model_en = 0;
    rv = tbl[0];
    load(rv, 32);
    cyc = 0;
    while (acc_start && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_wait0_err", err_timeout, 0);
    repeat (7) @(negedge clk);
    chk("to_wait7_err", err_timeout, 0);
    chk("to_wait7_busy", busy, 1);
    @(negedge clk);
    chk("to_err", err_timeout, 1);
    chk("to_in_ready", in_ready, 1);
    chk("to_busy", busy, 0);
    chk("to_out_valid", out_valid, 0);
    model_en = 1;
    // Reset after 10 bytes, then a fresh batch.
    load(tbl[1], 10);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_err_timeout", err_timeout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_acc_a", acc_a == '0, 1);
    chk("mid_rst_acc_b", acc_b == '0, 1);
    rst = 0;
    #1 chk("mid_rst_release_in_ready", in_ready, 1);
    run_batch(tbl[1], 0);
    // Corrupted C[2][1]: drained as returned, flagged only when the checker is built in.
    rv = tbl[1];
    rv.corrupt = 1;
    run_batch(rv, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mat_add_host.md
MAT_ADD_HOST -- requirements
Module: mat_add_host

Interface
REQ-001 SHALL have parameter START_CYCLES, default 2, width of acc_start pulse in clk cycles (1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, max cycles to wait for acc_done after start pulse ends (1..65535).
REQ-003 SHALL use one clock and one synchronous, active-high reset; all ports below are listed as name, direction, width, meaning.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand byte valid.
REQ-007 in_ready  output  1  operand byte accepted when in_valid&in_ready.
REQ-008 in_data  input  8  operand byte; order A[0][0]..A[3][3] then B[0][0]..B[3][3], row-major.
REQ-009 acc_a, acc_b  output  4x4x8  operand matrices driven to the adder.
REQ-010 acc_start  output  1  start pulse to the adder.
REQ-011 acc_done  input  1  adder completion.
REQ-012 acc_c  input  4x4x16  adder result.
REQ-013 out_valid  output  1  result word valid.
REQ-014 out_ready  input  1  result word consumed when out_valid&out_ready.
REQ-015 out_data  output  16  result word, C[0][0]..C[3][3] row-major.
REQ-016 out_last  output  1  high with the 16th result word.
REQ-017 busy  output  1  high in any state other than LOAD.
REQ-018 err_timeout  output  1  sticky, acc_done never seen.
REQ-019 err_mismatch  output  1  sticky, result check failure (see Configuration).

Function
REQ-020 SHALL implement FSM states LOAD, START, WAIT, DRAIN.
REQ-021 LOAD: in_ready=1; each accepted byte is written to the element given by a 5-bit counter (0-15 A, 16-31 B); no other state asserts in_ready.
REQ-022 Acceptance of byte 31 SHALL move to START on the next cycle and clear the load counter.
REQ-023 START: acc_start=1 for exactly START_CYCLES consecutive cycles, then WAIT; acc_a/acc_b SHALL stay stable from START until the next LOAD write.
REQ-024 WAIT: acc_start=0; a cycle counter counts from 0; acc_done=1 SHALL capture all 16 acc_c words into a local result buffer in that cycle and enter DRAIN.
REQ-025 If TIMEOUT_CYCLES cycles elapse in WAIT without acc_done, SHALL set err_timeout, discard the batch, and return to LOAD.
REQ-026 acc_done asserted during START SHALL be ignored.
REQ-027 DRAIN: out_valid=1; out_data=buffer[idx]; idx advances only on handshake; out_data SHALL hold while out_ready=0.
REQ-028 Handshake with idx=15 (out_last=1) SHALL return to LOAD next cycle with out_valid=0.
REQ-029 Result words SHALL be taken from the capture buffer, never live acc_c, during DRAIN.
REQ-030 Throughput SHALL be one byte/word per cycle in LOAD/DRAIN under continuous valid/ready.

Reset
REQ-031 rst=1 at any clock edge, including mid-LOAD/WAIT/DRAIN, SHALL force LOAD, clear all counters/indices, clear acc_a, acc_b and the buffer to 0, and drive acc_start=0, out_valid=0, out_last=0, busy=0, in_ready=0 during reset, err_timeout=0, err_mismatch=0.
REQ-032 in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-033 Macro MAT_ADD_HOST_CHECK_EN defined: during the capture cycle each acc_c[i][j] SHALL be compared to zero-extended acc_a[i][j]+acc_b[i][j]; any difference sets err_mismatch (sticky until rst).
REQ-034 Macro undefined: no checker logic; err_mismatch SHALL be tied 0; all other behaviour is identical.

Verification
REQ-035 Bytes A all 0xFF, B all 0x01, model adder with done 3 cycles after start -> 16 words 0x0100, out_last on word 16 only, err flags 0.
REQ-036 acc_done held 0, TIMEOUT_CYCLES=8 -> err_timeout=1 exactly 8 cycles after WAIT entry, state LOAD, in_ready=1, no out_valid.
REQ-037 out_ready toggling 1-0-1-0 during DRAIN -> each word held until handshake, order C[0][0]..C[3][3], 16 handshakes total.
REQ-038 rst pulsed 1 cycle after 10 bytes loaded -> all outputs at reset values, next 32 bytes form a fresh batch with correct results (A=i, B=2i -> C=3i).
REQ-039 With MAT_ADD_HOST_CHECK_EN, model adder returns C[2][1] off by 1 -> err_mismatch=1 after capture, data still drained unchanged; without the macro err_mismatch stays 0.
REQ-040 START_CYCLES=2: acc_start high exactly 2 cycles; acc_done pulse inside START ignored; later acc_done in WAIT captured.
